// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready word intake, framed
// serial output, optional idle gap between words and last-bit pulse.
module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         serial_o,
  output logic         frame_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_S} state_t;

  state_t        state;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;

  logic          last_bit;
  logic          hs;
  logic          first_bit;
  logic          next_bit;
  logic [N-1:0]  load_sr;
  logic [N-1:0]  shift_sr;

  // Handshake and bit selection depend only on state and current word.
  always_comb begin
    last_bit  = (state == SHIFT) && (cnt == '0);
    ready_o   = (state == IDLE) || (last_bit && (GAP == 0));
    hs        = valid_i && ready_o;
    busy_o    = (state != IDLE);
    first_bit = MSB_FIRST ? data_i[N-1] : data_i[0];
    load_sr   = MSB_FIRST ? (data_i << 1) : (data_i >> 1);
    next_bit  = MSB_FIRST ? sr[N-1] : sr[0];
    shift_sr  = MSB_FIRST ? (sr << 1) : (sr >> 1);
  end

  // FSM with registered serial outputs; a load presents the first bit at once
  // so it shows up one cycle after the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      serial_o <= 1'b0;
      frame_o  <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          serial_o <= 1'b0;
          frame_o  <= 1'b0;
          if (hs) begin
            state    <= SHIFT;
            sr       <= load_sr;
            cnt      <= CNT_LOAD;
            serial_o <= first_bit;
            frame_o  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            serial_o <= next_bit;
            frame_o  <= 1'b1;
            sr       <= shift_sr;
            cnt      <= cnt - 1'b1;
            done_o   <= (cnt == CW'(1));
          end else if (GAP > 0) begin
            state    <= GAP_S;
            gcnt     <= GAP_LAST;
            serial_o <= 1'b0;
            frame_o  <= 1'b0;
          end else if (hs) begin
            // back-to-back word: no bubble between frames
            sr       <= load_sr;
            cnt      <= CNT_LOAD;
            serial_o <= first_bit;
            frame_o  <= 1'b1;
          end else begin
            state    <= IDLE;
            serial_o <= 1'b0;
            frame_o  <= 1'b0;
          end
        end
        GAP_S: begin
          serial_o <= 1'b0;
          frame_o  <= 1'b0;
          if (gcnt == '0) state <= IDLE;
          else            gcnt  <= gcnt - 1'b1;
        end
        default: begin
          state    <= IDLE;
          serial_o <= 1'b0;
          frame_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations (MSB/GAP0, LSB/GAP0,
// MSB/GAP2) driven from a vector table plus hand-written multi-cycle cases.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat [3];
  logic       vld [3];
  logic       rdy [3];
  logic       ser [3];
  logic       frm [3];
  logic       bsy [3];
  logic       dne [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.N(8), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dat[0]), .valid_i(vld[0]),
    .ready_o(rdy[0]), .serial_o(ser[0]), .frame_o(frm[0]), .busy_o(bsy[0]), .done_o(dne[0]));
  piso_serializer #(.N(8), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dat[1]), .valid_i(vld[1]),
    .ready_o(rdy[1]), .serial_o(ser[1]), .frame_o(frm[1]), .busy_o(bsy[1]), .done_o(dne[1]));
  piso_serializer #(.N(8), .MSB_FIRST(1'b1), .GAP(2)) u_gap (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dat[2]), .valid_i(vld[2]),
    .ready_o(rdy[2]), .serial_o(ser[2]), .frame_o(frm[2]), .busy_o(bsy[2]), .done_o(dne[2]));

  typedef struct {
    int         sel;   // which instance
    logic [7:0] word;  // parallel input
    logic [7:0] exp;   // expected serial bits, first-sent in bit 7
    int         gap;   // idle gap of that instance
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Check all status outputs of one instance against an expected tuple.
  task automatic chk_out(input string nm, input int s, input logic e_ser,
                         input logic e_frm, input logic e_bsy, input logic e_dne);
    chk({nm, ".serial"}, ser[s], e_ser);
    chk({nm, ".frame"},  frm[s], e_frm);
    chk({nm, ".busy"},   bsy[s], e_bsy);
    chk({nm, ".done"},   dne[s], e_dne);
  endtask

  // Expects to be called on a negedge with the instance idle.
  task automatic run_word(input int s, input logic [7:0] w, input logic [7:0] exp,
                          input int gap);
    vld[s] = 1'b1;
    dat[s] = w;
    @(negedge clk);
    vld[s] = 1'b0;
    dat[s] = ~w;  // must not leak into the word being sent
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("w%0d_%02h_b%0d", s, w, i), s, exp[7-i], 1'b1, 1'b1, i == 7);
      chk($sformatf("w%0d_%02h_b%0d.ready", s, w, i), rdy[s], (i == 7) && (gap == 0));
      @(negedge clk);
    end
    for (int g = 0; g < gap; g++) begin
      chk_out($sformatf("w%0d_%02h_gap%0d", s, w, g), s, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("w%0d_%02h_gap%0d.ready", s, w, g), rdy[s], 1'b0);
      @(negedge clk);
    end
    chk_out($sformatf("w%0d_%02h_idle", s, w), s, 1'b0, 1'b0, 1'b0, 1'b0);
    chk($sformatf("w%0d_%02h_idle.ready", s, w), rdy[s], 1'b1);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      vld[s] = 1'b0;
      dat[s] = 8'h00;
    end
    vecs[0] = '{sel: 0, word: 8'hA5, exp: 8'hA5, gap: 0};
    vecs[1] = '{sel: 0, word: 8'h3C, exp: 8'h3C, gap: 0};
    vecs[2] = '{sel: 1, word: 8'h01, exp: 8'h80, gap: 0};
    vecs[3] = '{sel: 1, word: 8'h0B, exp: 8'hD0, gap: 0};
    vecs[4] = '{sel: 2, word: 8'hFF, exp: 8'hFF, gap: 2};
    vecs[5] = '{sel: 2, word: 8'h96, exp: 8'h96, gap: 2};

    // reset held for 3 cycles
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) chk_out($sformatf("rst%0d", s), s, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("rst%0d.ready", s), rdy[s], 1'b1);

    // table-driven single words
    for (int k = 0; k < 6; k++) begin
      run_word(vecs[k].sel, vecs[k].word, vecs[k].exp, vecs[k].gap);
      @(negedge clk);
    end

    // GAP=0 back-to-back: valid held, 0xF0 then 0x0F, 16 contiguous bits
    vld[0] = 1'b1;
    dat[0] = 8'hF0;
    @(negedge clk);
    dat[0] = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] e = 16'hF00F;
      if (i == 8) vld[0] = 1'b0;
      chk_out($sformatf("b2b_b%0d", i), 0, e[15-i], 1'b1, 1'b1, (i == 7) || (i == 15));
      @(negedge clk);
    end
    chk_out("b2b_end", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // GAP=2 back-to-back: 0xFF, 2 gap cycles, 1 idle cycle, then 0x00
    @(negedge clk);
    vld[2] = 1'b1;
    dat[2] = 8'hFF;
    @(negedge clk);
    dat[2] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("gap_ff_b%0d", i), 2, 1'b1, 1'b1, 1'b1, i == 7);
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) begin
      chk_out($sformatf("gap_g%0d", g), 2, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("gap_g%0d.ready", g), rdy[2], 1'b0);
      @(negedge clk);
    end
    chk_out("gap_idle", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_idle.ready", rdy[2], 1'b1);
    @(negedge clk);
    vld[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("gap_00_b%0d", i), 2, 1'b0, 1'b1, 1'b1, i == 7);
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) @(negedge clk);
    chk_out("gap_end", 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset during bit 3 of 0xC3 (bits 1,1,0,0,...)
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'hC3;
    @(negedge clk);
    vld[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e = 8'hC3;
      chk_out($sformatf("abort_b%0d", i), 0, e[7-i], 1'b1, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_out("abort_b3", 0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("abort_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("abort_quiet%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    run_word(0, 8'h81, 8'h81, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
